// File: rtl/nibble_serial_subtractor.sv
// Slice-serial subtractor: diff = a - b - borrowIn, SLICE bits per clock, LSB slice first.
// Results load into the output registers on the edge entering DONE and hold until the next completion.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = SLICE + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] wdiff_q, wdiff_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] a_s, b_s, slice_d;
    logic [SLICE:0]   slice_res;
    logic             slice_bout;
    logic             msb_borrow;

    // Current slice: operands shift right so the active slice always sits in the low bits.
    always_comb begin
        a_s        = a_q[SLICE-1:0];
        b_s        = b_q[SLICE-1:0];
        slice_res  = {1'b0, a_s} - {1'b0, b_s} - SW'(borrow_q);
        slice_d    = slice_res[SLICE-1:0];
        slice_bout = slice_res[SLICE];
        // Borrow into the slice's top bit recovered from its sum bit: d = a ^ b ^ bin.
        msb_borrow = slice_d[SLICE-1] ^ a_s[SLICE-1] ^ b_s[SLICE-1];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        borrow_d     = borrow_q;
        wdiff_d      = wdiff_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = borrowIn;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d      = a_q >> SLICE;
                b_d      = b_q >> SLICE;
                wdiff_d  = {slice_d, wdiff_q[WIDTH-1:SLICE]};
                borrow_d = slice_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d      = S_DONE;
                    diff_d       = wdiff_d;
                    borrow_out_d = slice_bout;
                    overflow_d   = msb_borrow ^ slice_bout;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            wdiff_q      <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            borrow_q     <= borrow_d;
            wdiff_q      <= wdiff_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign diff      = diff_q;
    assign borrowOut = borrow_out_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor: computes diff = a − b − borrowIn one SLICE-bit slice per clock, LSB slice first, with the inter-slice borrow held in a register. It is the subtract-side counterpart of the team's ripple-carry adder blocks and the arithmetic unit's low-area subtract path. Operands are captured on a start handshake. Results are published with a one-cycle done pulse and held until the next operation completes.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; N = WIDTH/SLICE slices.
- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  WIDTH  minuend, sampled on accepted start.
- b  input  WIDTH  subtrahend, sampled on accepted start.
- borrowIn  input  1  initial borrow, sampled on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result registers just updated.
- diff  output  WIDTH  registered result.
- borrowOut  output  1  final borrow; 1 iff unsigned a < b + borrowIn.
- overflow  output  1  signed overflow = (borrow into MSB) XOR borrowOut.

## Operation
- Only synchronous reset. Clock and reset are as decided: one clock, reset synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, diff 0, borrowOut 0, overflow 0, slice counter 0, internal operand/borrow registers 0.
- States:
  - IDLE: start=1 latches a, b, borrowIn into working registers, clears the counter, and moves to RUN.
  - RUN: each cycle computes slice k = counter. The slice value is {bout, d[SLICE-1:0]} = a[k] − b[k] − borrowReg, with 1 extra bit. d is written into the working diff register, borrowReg ← bout, and the counter increments. For k = N−1, the borrow into the MSB is also captured. At counter = N−1 the next state is DONE, and diff/borrowOut/overflow output registers load from the working values on that same edge.
  - DONE: done=1 for exactly one cycle. Next state is IDLE, or RUN if start=1 in this cycle, which latches new operands.
- start in RUN is ignored: no queuing, no effect on the current operation.
- Outputs diff/borrowOut/overflow change only on the edge entering DONE. They hold otherwise, including through a subsequent RUN.
- Arithmetic is modulo 2^WIDTH; borrowOut is the borrow out of bit WIDTH−1.
- Operand inputs are don't-care except in the cycle start is accepted.

## Timing
- start accepted at the rising edge ending cycle T.
- busy=1 in cycles T+1 … T+N; slice k is written at the edge ending cycle T+1+k.
- done=1 and new results visible in cycle T+N+1; latency is N+1 cycles from start to done (9 for the defaults).
- Back-to-back: start held through DONE gives a throughput of one result per N+1 cycles, and busy rises in cycle T+N+2.
- reset=1 in any cycle takes effect at that edge: the operation is aborted, no done pulse, and all outputs return to reset values in the next cycle. start asserted together with reset is ignored.
- busy and done are never high in the same cycle.

## Test plan
- Reset, then a=0x0000000B, b=0x0000000A, borrowIn=0, start 1 cycle -> busy high 8 cycles, done pulse exactly 9 cycles after start, diff=0x00000001, borrowOut=0, overflow=0.
- a=0x00000016, b=0x0000000E, borrowIn=1 -> diff=0x00000007, borrowOut=0, overflow=0. a=0x00000000, b=0x00000001, borrowIn=0 -> diff=0xFFFFFFFF, borrowOut=1, overflow=0.
- Overflow boundaries:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrowOut=0, overflow=1.
  - a=0x80000000, b=0, borrowIn=1 -> diff=0x7FFFFFFF, overflow=1.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrowOut=1, overflow=1.
- Pulse start again 3 cycles into RUN with different operands -> ignored; the done timing and result match the first operands, and diff holds the old value until done.
- Assert reset for 1 cycle at the 5th busy cycle -> no done pulse; diff/borrowOut/overflow/busy = 0 the next cycle; a fresh start then completes normally.
- Hold start high with new operands during the DONE cycle -> the second operation begins immediately, and its done arrives 9 cycles after the first done with the correct second result.
